// File: rtl/itch_message_encoder.sv
// Serialises one ITCH 5.0 message per accepted command into a big-endian byte stream.
// Supports types A, X, D, U, E and P. Any other type is accepted, dropped and flagged on cmd_reject.
//
// state | meaning
// IDLE  | cmd_ready=1, waiting for a command
// SEND  | streaming bytes 0..len-1 of the latched message
// GAP   | holding valid_out low for GAP_CYCLES cycles after the last byte
module itch_message_encoder #(
  parameter int GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_type,
  input  logic [15:0] cmd_locate,
  input  logic [15:0] cmd_tracking,
  input  logic [47:0] cmd_timestamp,
  input  logic [63:0] cmd_order_ref,
  input  logic [63:0] cmd_new_ref,
  input  logic [7:0]  cmd_side,
  input  logic [31:0] cmd_shares,
  input  logic [31:0] cmd_price,
  input  logic [63:0] cmd_stock,
  input  logic [63:0] cmd_match_id,
  output logic [7:0]  byte_out,
  output logic        valid_out,
  input  logic        out_ready,
  output logic        cmd_reject,
  output logic        msg_done
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam logic [7:0] T_ADD      = 8'h41;  // 'A'
  localparam logic [7:0] T_CANCEL   = 8'h58;  // 'X'
  localparam logic [7:0] T_DELETE   = 8'h44;  // 'D'
  localparam logic [7:0] T_REPLACE  = 8'h55;  // 'U'
  localparam logic [7:0] T_EXECUTED = 8'h45;  // 'E'
  localparam logic [7:0] T_TRADE    = 8'h50;  // 'P'

  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_t      state;
  logic [5:0]  idx_q;
  logic [5:0]  last_idx_q;
  logic [3:0]  gap_cnt_q;

  logic [7:0]  type_q;
  logic [15:0] locate_q;
  logic [15:0] tracking_q;
  logic [47:0] timestamp_q;
  logic [63:0] order_ref_q;
  logic [63:0] new_ref_q;
  logic [7:0]  side_q;
  logic [31:0] shares_q;
  logic [31:0] price_q;
  logic [63:0] stock_q;
  logic [63:0] match_id_q;

  function automatic logic is_supported(input logic [7:0] t);
    return (t == T_ADD) || (t == T_CANCEL) || (t == T_DELETE) ||
           (t == T_REPLACE) || (t == T_EXECUTED) || (t == T_TRADE);
  endfunction

  function automatic logic [5:0] last_index(input logic [7:0] t);
    logic [5:0] li;
    case (t)
      T_ADD:      li = 6'd35;
      T_CANCEL:   li = 6'd22;
      T_DELETE:   li = 6'd18;
      T_REPLACE:  li = 6'd34;
      T_EXECUTED: li = 6'd30;
      T_TRADE:    li = 6'd43;
      default:    li = 6'd0;
    endcase
    return li;
  endfunction

  // Whole message left-aligned in a 44-byte vector; byte i sits at bits [351-8i -: 8].
  logic [151:0] header;
  logic [351:0] msg_vec;
  logic [351:0] msg_shifted;
  logic [5:0]   next_idx;
  logic [7:0]   next_byte;

  always_comb begin
    header = {type_q, locate_q, tracking_q, timestamp_q, order_ref_q};
    msg_vec = '0;
    case (type_q)
      T_ADD:      msg_vec = {header, side_q, shares_q, stock_q, price_q, 64'd0};
      T_CANCEL:   msg_vec = {header, shares_q, 168'd0};
      T_DELETE:   msg_vec = {header, 200'd0};
      T_REPLACE:  msg_vec = {header, new_ref_q, shares_q, price_q, 72'd0};
      T_EXECUTED: msg_vec = {header, shares_q, match_id_q, 104'd0};
      T_TRADE:    msg_vec = {header, side_q, shares_q, stock_q, price_q, match_id_q};
      default:    msg_vec = '0;
    endcase
  end

  assign next_idx    = idx_q + 6'd1;
  assign msg_shifted = msg_vec << {next_idx, 3'b000};
  assign next_byte   = msg_shifted[351:344];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      valid_out   <= 1'b0;
      byte_out    <= 8'd0;
      cmd_reject  <= 1'b0;
      msg_done    <= 1'b0;
      idx_q       <= 6'd0;
      last_idx_q  <= 6'd0;
      gap_cnt_q   <= 4'd0;
      type_q      <= 8'd0;
      locate_q    <= 16'd0;
      tracking_q  <= 16'd0;
      timestamp_q <= 48'd0;
      order_ref_q <= 64'd0;
      new_ref_q   <= 64'd0;
      side_q      <= 8'd0;
      shares_q    <= 32'd0;
      price_q     <= 32'd0;
      stock_q     <= 64'd0;
      match_id_q  <= 64'd0;
    end else begin
      cmd_reject <= 1'b0;
      msg_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            if (is_supported(cmd_type)) begin
              type_q      <= cmd_type;
              locate_q    <= cmd_locate;
              tracking_q  <= cmd_tracking;
              timestamp_q <= cmd_timestamp;
              order_ref_q <= cmd_order_ref;
              new_ref_q   <= cmd_new_ref;
              side_q      <= cmd_side;
              shares_q    <= cmd_shares;
              price_q     <= cmd_price;
              stock_q     <= cmd_stock;
              match_id_q  <= cmd_match_id;
              idx_q       <= 6'd0;
              last_idx_q  <= last_index(cmd_type);
              byte_out    <= cmd_type;  // byte 0 is always the type
              valid_out   <= 1'b1;
              cmd_ready   <= 1'b0;
              state       <= SEND;
            end else begin
              cmd_reject <= 1'b1;
            end
          end
        end
        SEND: begin
          if (out_ready) begin
            if (idx_q == last_idx_q) begin
              valid_out <= 1'b0;
              byte_out  <= 8'd0;
              msg_done  <= 1'b1;
              if (GAP_CYCLES == 0) begin
                state     <= IDLE;
                cmd_ready <= 1'b1;
              end else begin
                gap_cnt_q <= GAP_LOAD;
                state     <= GAP;
              end
            end else begin
              idx_q    <= next_idx;
              byte_out <= next_byte;
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == 4'd0) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q - 4'd1;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
